// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package riscv_ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   // Major opcodes handled by the control FSM
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   // Branch funct3 values that are supported
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1000;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU operation decoder: opcode/funct3/funct7[5] -> ALU op code.
// Latency: purely combinational.
// Backpressure: none.
module alu_ctrl_dec
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_b5,
   output logic [3:0] alu_op
);

   // Loads/stores compute addresses with ADD, branches compare with SUB
   always_comb begin
      alu_op = ALU_ADD;
      if (opcode == OP_BR) begin
         alu_op = ALU_SUB;
      end else if (opcode == OP_R || opcode == OP_I) begin
         case (funct3)
            3'b000:  alu_op = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            3'b100:  alu_op = ALU_XOR;
            3'b010:  alu_op = ALU_SLT;
            3'b001:  alu_op = ALU_SLL;
            3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
            default: alu_op = ALU_ADD;
         endcase
      end
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control FSM driving datapath selects and strobes.
// Latency: R/I 4 clk, LD 5, ST 4, BR 3 with memory ready in the same cycle.
// Backpressure: mem_ready stalls FETCH/MEM; too long a stall traps.
module mc_ctrl_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W   = 4,
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            opcode,
   input  logic [2:0]            funct3,
   input  logic                  funct7_b5,
   input  logic                  alu_zero,
   input  logic                  mem_ready,
   output logic                  ALUsrc,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   output logic                  pc_write,
   output logic                  pc_src,
   output logic                  ir_write,
   output logic                  reg_write,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  mem_to_reg,
   output logic                  illegal
);

   localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic [3:0]       dec_op;
   logic             is_r, is_i, is_ld, is_st, is_br;
   logic             waiting, wait_expired;

   // Combinational values before reset gating
   logic       alu_src_c, pc_write_c, pc_src_c, ir_write_c, reg_write_c;
   logic       mem_read_c, mem_write_c, mem_to_reg_c, illegal_c;
   logic [3:0] alu_sel_c;

   alu_ctrl_dec u_alu_ctrl_dec (
      .opcode    (opcode),
      .funct3    (funct3),
      .funct7_b5 (funct7_b5),
      .alu_op    (dec_op)
   );

   assign is_r  = (opcode == OP_R);
   assign is_i  = (opcode == OP_I);
   assign is_ld = (opcode == OP_LD);
   assign is_st = (opcode == OP_ST);
   assign is_br = (opcode == OP_BR);

   assign waiting      = (state == FETCH || state == MEM) && !mem_ready;
   assign wait_expired = (wait_cnt >= CNT_W'(MEM_WAIT_MAX - 1));

   // State register and consecutive memory-stall counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FETCH;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) begin
            wait_cnt <= '0;
         end else if (waiting) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
      end
   end

   // Next-state and per-state datapath controls
   always_comb begin
      state_nxt    = state;
      alu_src_c    = 1'b0;
      alu_sel_c    = ALU_ADD;
      pc_write_c   = 1'b0;
      pc_src_c     = 1'b0;
      ir_write_c   = 1'b0;
      reg_write_c  = 1'b0;
      mem_read_c   = 1'b0;
      mem_write_c  = 1'b0;
      mem_to_reg_c = 1'b0;
      illegal_c    = 1'b0;
      case (state)
         FETCH: begin
            mem_read_c = 1'b1;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               state_nxt  = DECODE;
            end else if (wait_expired) begin
               state_nxt = TRAP;
            end
         end
         DECODE: begin
            state_nxt = (is_r || is_i || is_ld || is_st || is_br) ? EXEC : TRAP;
         end
         EXEC: begin
            alu_src_c = is_i || is_ld || is_st;
            alu_sel_c = dec_op;
            if (is_r || is_i) begin
               state_nxt = WB;
            end else if (is_ld || is_st) begin
               state_nxt = MEM;
            end else if (is_br && (funct3 == F3_BEQ || funct3 == F3_BNE)) begin
               // BEQ takes on zero difference, BNE on non-zero
               if ((funct3 == F3_BEQ) == alu_zero) begin
                  pc_write_c = 1'b1;
                  pc_src_c   = 1'b1;
               end
               state_nxt = FETCH;
            end else begin
               state_nxt = TRAP;
            end
         end
         MEM: begin
            // Address operands stay selected for the whole access
            alu_src_c   = 1'b1;
            alu_sel_c   = dec_op;
            mem_read_c  = is_ld;
            mem_write_c = is_st;
            if (mem_ready) begin
               state_nxt = is_ld ? WB : FETCH;
            end else if (wait_expired) begin
               state_nxt = TRAP;
            end
         end
         WB: begin
            reg_write_c  = 1'b1;
            mem_to_reg_c = is_ld;
            state_nxt    = FETCH;
         end
         TRAP: begin
            illegal_c = 1'b1;
         end
         default: begin
            state_nxt = TRAP;
         end
      endcase
   end

   // Reset forces every output low, even while the state already reads FETCH
   assign ALUsrc     = !rst && alu_src_c;
   assign alu_ctrl   = rst ? '0 : ALU_CTRL_W'(alu_sel_c);
   assign pc_write   = !rst && pc_write_c;
   assign pc_src     = !rst && pc_src_c;
   assign ir_write   = !rst && ir_write_c;
   assign reg_write  = !rst && reg_write_c;
   assign mem_read   = !rst && mem_read_c;
   assign mem_write  = !rst && mem_write_c;
   assign mem_to_reg = !rst && mem_to_reg_c;
   assign illegal    = !rst && illegal_c;

endmodule
